// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch and the
//   MEM stage (loads/stores). Exactly one request/ack transaction is
//   outstanding at a time. Data requests normally win, but a fetch is forced
//   through after MAX_STARVE consecutive data grants that left it waiting. A
//   watchdog aborts any transaction whose ack does not arrive within TIMEOUT
//   cycles.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   if_req/if_addr           fetch read request (level) and address
//   if_rdata/if_ready        fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (level), store flag, address, data
//   d_rdata/d_ready          load data and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request side
//   mem_rdata/mem_ack        memory read data and one-cycle completion
//   stall_if/stall_mem       combinational stalls into hazard control
//   bus_err                  pulse coincident with the ready of an aborted access
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          bus_err
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(MAX_STARVE);
    localparam logic [WW-1:0] WD_LAST_C    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [WW-1:0]   wd_cnt_r;

    logic            if_elig_s;
    logic            d_elig_s;
    logic            turnaround_s;
    logic            grant_i_s;
    logic            grant_d_s;
    logic            done_s;
    logic            abort_s;
    logic            is_fetch_s;

    // A requester whose ready pulse is high this cycle is being answered and
    // may already be presenting its next request; it must not be re-granted.
    assign if_elig_s    = if_req & ~if_ready;
    assign d_elig_s     = d_req  & ~d_ready;
    // The cycle carrying a ready pulse is a turnaround cycle: no grant is
    // made in it, so arbitration always sees both requesters on equal terms
    // in the following IDLE cycle.
    assign turnaround_s = if_ready | d_ready;
    assign is_fetch_s   = (state_r == BUSY_I);

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req  & ~d_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/abort in BUSY.
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (turnaround_s) begin
                    state_next_s = IDLE;
                end else if (d_elig_s && !(if_elig_s && (starve_cnt_r == STARVE_MAX_C))) begin
                    grant_d_s    = 1'b1;
                    state_next_s = BUSY_D;
                end else if (if_elig_s) begin
                    grant_i_s    = 1'b1;
                    state_next_s = BUSY_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                // A late ack arriving on the watchdog's last cycle still counts.
                if (mem_ack) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else if (wd_cnt_r == WD_LAST_C) begin
                    abort_s      = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Memory request side, ready/error pulses, returned data and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            if_rdata     <= {DW{1'b0}};
            d_rdata      <= {DW{1'b0}};
            if_ready     <= 1'b0;
            d_ready      <= 1'b0;
            bus_err      <= 1'b0;
            starve_cnt_r <= {SW{1'b0}};
            wd_cnt_r     <= {WW{1'b0}};
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
            if (grant_i_s) begin
                mem_req      <= 1'b1;
                mem_we       <= 1'b0;
                mem_addr     <= if_addr;
                wd_cnt_r     <= {WW{1'b0}};
                starve_cnt_r <= {SW{1'b0}};
            end else if (grant_d_s) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                wd_cnt_r  <= {WW{1'b0}};
                // Only data grants that left a fetch waiting count toward starvation.
                if (if_req) begin
                    if (starve_cnt_r == STARVE_MAX_C) begin
                        starve_cnt_r <= starve_cnt_r;
                    end else begin
                        starve_cnt_r <= starve_cnt_r + SW'(1);
                    end
                end else begin
                    starve_cnt_r <= {SW{1'b0}};
                end
            end else if (done_s) begin
                mem_req <= 1'b0;
                if (is_fetch_s) begin
                    if_ready <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    d_ready <= 1'b1;
                    // A store completes without disturbing the last load value.
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        d_rdata <= d_rdata;
                    end
                end
            end else if (abort_s) begin
                mem_req <= 1'b0;
                bus_err <= 1'b1;
                if (is_fetch_s) begin
                    if_ready <= 1'b1;
                end else begin
                    d_ready <= 1'b1;
                end
            end else if (state_r != IDLE) begin
                wd_cnt_r <= wd_cnt_r + WW'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_STARVE = 4;
    localparam int TIMEOUT    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;     // mem_req cycles before ack; >= TIMEOUT means never
        logic [31:0] rdata;       // value the memory returns
        logic [31:0] exp_rdata;   // requester's rdata at its ready pulse
        bit          exp_err;
        int          exp_lat;     // clock edges from request to ready pulse
        int          exp_memcyc;  // cycles mem_req stays high
    } vec_t;

    // Reference model state (random phase).
    int          m_own;   // 0 none, 1 fetch, 2 data
    int          m_wait;
    int          m_starve;
    bit          m_ir, m_dr, m_err, m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    // One isolated transaction; entered and left with the arbiter idle.
    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        int  memcyc;
        bit  got;
        bit  first;
        logic rdy;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        mem_rdata = v.rdata;
        mem_ack   = 1'b0;
        #1;
        check({tag, " stall"}, v.is_d ? stall_mem : stall_if, 1'b1);
        lat = 0; memcyc = 0; got = 1'b0; first = 1'b1;
        while (!got && lat < 200) begin
            tick();
            lat++;
            rdy = v.is_d ? d_ready : if_ready;
            if (rdy) begin
                got = 1'b1;
                check({tag, " rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
                check({tag, " bus_err"}, bus_err, v.exp_err);
                check({tag, " mem_req low"}, mem_req, 1'b0);
                check({tag, " latency"}, lat, v.exp_lat);
                check({tag, " mem_req cycles"}, memcyc, v.exp_memcyc);
                check({tag, " stall at ready"}, v.is_d ? stall_mem : stall_if, 1'b0);
                mem_ack = 1'b0;
                if_req  = 1'b0;
                d_req   = 1'b0;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (first) begin
                        first = 1'b0;
                        check({tag, " mem_addr"}, mem_addr, v.addr);
                        check({tag, " mem_we"}, mem_we, v.we);
                        if (v.is_d && v.we) check({tag, " mem_wdata"}, mem_wdata, v.wdata);
                    end
                    mem_ack = (memcyc == v.ack_dly);
                    memcyc++;
                end
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no ready pulse within 200 cycles", tag);
        end
        tick();
        check({tag, " pulse width"}, {if_ready, d_ready, bus_err, mem_req}, 4'b0000);
    endtask

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model_step();
        bit n_ir = 1'b0, n_dr = 1'b0, n_err = 1'b0;
        bit take_i;
        if (m_own != 0) begin
            if (mem_ack || m_wait == TIMEOUT - 1) begin
                n_err = !mem_ack;
                if (m_own == 1) begin
                    n_ir = 1'b1;
                    if (mem_ack) m_ird = mem_rdata;
                end else begin
                    n_dr = 1'b1;
                    if (mem_ack && !m_we) m_drd = mem_rdata;
                end
                m_own = 0;
                m_req = 1'b0;
            end else begin
                m_wait++;
            end
        end else if (!m_ir && !m_dr) begin
            take_i = if_req && (!d_req || m_starve == MAX_STARVE);
            if (take_i) begin
                m_own = 1; m_req = 1'b1; m_we = 1'b0; m_addr = if_addr;
                m_wait = 0; m_starve = 0;
            end else if (d_req) begin
                m_own = 2; m_req = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                m_wait = 0;
                m_starve = if_req ? ((m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE) : 0;
            end
        end
        m_ir = n_ir; m_dr = n_dr; m_err = n_err;
    endtask

    vec_t vecs[7];

    initial begin
        vec_t rv;
        int   ev;
        logic [9:0] ord;
        int   r1, r2, mc, nrdy;
        bit   seen, prev_req, no_ack;

        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        2,    32'h8C020004, 32'h8C020004, 1'b0, 4,  3};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        0,    32'h11112222, 32'h11112222, 1'b0, 2,  1};
        vecs[2] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1,    32'h55555555, 32'h11112222, 1'b0, 3,  2};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        1000, 32'h77777777, 32'h11112222, 1'b1, 65, 64};
        vecs[4] = '{1'b0, 1'b0, 32'h44,  32'h0,        1000, 32'h66666666, 32'h8C020004, 1'b1, 65, 64};
        vecs[5] = '{1'b1, 1'b0, 32'h14,  32'h0,        3,    32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 5,  4};
        vecs[6] = '{1'b0, 1'b0, 32'h48,  32'h0,        0,    32'h01234567, 32'h01234567, 1'b0, 2,  1};

        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("reset ctrl", {mem_req, mem_we, if_ready, d_ready, bus_err}, 5'b00000);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset rdata", {if_rdata, d_rdata}, 64'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Contention: both held continuously, ack in the first mem_req cycle.
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        mem_ack = 1'b0; ev = 0; ord = 10'b0;
        for (int c = 0; c < 300 && ev < 10; c++) begin
            tick();
            if (if_ready) begin
                ord[ev] = 1'b1;
                ev++;
            end else if (d_ready) begin
                ev++;
            end
            mem_ack = mem_req;
        end
        check("contention grants", ev, 10);
        check("contention order", ord, 10'b1000010000);
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick();
        tick();

        // Back-to-back loads, ack one cycle after mem_req rises.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; mem_rdata = 32'hAAAA0010;
        mem_ack = 1'b0; r1 = -1; r2 = -1; mc = 0; nrdy = 0;
        for (int c = 0; c < 60 && nrdy < 2; c++) begin
            tick();
            if (d_ready) begin
                if (nrdy == 0) begin
                    r1 = c;
                    check("b2b first rdata", d_rdata, 32'hAAAA0010);
                    d_addr = 32'h14;
                end else begin
                    r2 = c;
                    check("b2b second rdata", d_rdata, 32'hBBBB0014);
                    d_req = 1'b0;
                end
                nrdy++;
                mc = 0;
            end
            if (r1 >= 0 && (c == r1 || c == r1 + 1)) check("b2b gap mem_req", mem_req, 1'b0);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (mc == 0 && r1 >= 0) check("b2b second addr", mem_addr, 32'h14);
                mem_ack = (mc == 1);
                mc++;
            end
            mem_rdata = (r1 < 0) ? 32'hAAAA0010 : 32'hBBBB0014;
        end
        check("b2b ready spacing", r2 - r1, 4);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Reset in the middle of a fetch.
        if_req = 1'b1; if_addr = 32'h60; seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = mem_req;
        end
        check("rst mid: mem_req raised", seen, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst mid: mem_req drops at once", mem_req, 1'b0);
        if_req = 1'b0;
        tick();
        check("rst mid: no ready 1", {if_ready, bus_err, mem_req}, 3'b000);
        tick();
        check("rst mid: no ready 2", {if_ready, bus_err, mem_req}, 3'b000);
        rst = 1'b0;
        tick();
        check("rst mid: after release", {if_ready, mem_req}, 2'b00);
        rv = '{1'b0, 1'b0, 32'h64, 32'h0, 1, 32'h0BADC0DE, 32'h0BADC0DE, 1'b0, 3, 2};
        run_vec(rv, "post-reset fetch");

        // Random phase against the reference model.
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        m_own = 0; m_wait = 0; m_starve = 0;
        m_ir = 0; m_dr = 0; m_err = 0; m_req = 0; m_we = 0;
        m_addr = 32'h0; m_wdata = 32'h0; m_ird = 32'h0; m_drd = 32'h0;
        prev_req = 1'b0; no_ack = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (m_req && !prev_req) no_ack = ($urandom_range(0, 24) == 0);
            prev_req = m_req;
            if (m_req) mem_ack = !no_ack && ($urandom_range(0, 2) == 0);
            else       mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            if (!(if_req && !m_ir)) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!(d_req && !m_dr)) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            #1;
            check("rand stall", {stall_if, stall_mem}, {if_req & ~m_ir, d_req & ~m_dr});
            model_step();
            tick();
            check("rand ctrl", {mem_req, mem_we, if_ready, d_ready, bus_err},
                  {m_req, m_we, m_ir, m_dr, m_err});
            check("rand mem_addr", mem_addr, m_addr);
            check("rand mem_wdata", mem_wdata, m_wdata);
            check("rand rdata", {if_rdata, d_rdata}, {m_ird, m_drd});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
